// File: rtl/priority_encoder8to3_if.sv
// Request/grant bundle between request sources and the control unit.
// The master drives requests, mask and acknowledge; the slave returns the grant.
interface priority_encoder8to3_if;
  logic [7:0] R;
  logic [7:0] MaskIn;
  logic       MaskLd;
  logic       Ack;
  logic       Clear;
  logic [2:0] S;
  logic       Valid;
  logic [7:0] Mask;
  logic [3:0] Count;

  modport master (
    output R, MaskIn, MaskLd, Ack, Clear,
    input  S, Valid, Mask, Count
  );

  modport slave (
    input  R, MaskIn, MaskLd, Ack, Clear,
    output S, Valid, Mask, Count
  );
endinterface

// File: rtl/priority_encoder8to3.sv
// Registered 8-to-3 priority encoder: sticky request latching, maskable selection,
// lowest index wins, and the grant is held until the consumer acknowledges it.
module priority_encoder8to3 (
  input logic                   Clock,
  input logic                   Resetn,
  priority_encoder8to3_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_pending;
  logic [7:0] w_nextPending;
  logic [7:0] r_mask;
  logic [7:0] w_clr;
  logic [7:0] w_eligible;
  logic [2:0] r_s;
  logic [2:0] w_nextS;
  logic [2:0] w_lowIdx;
  logic       r_valid;
  logic       w_nextValid;
  logic [3:0] w_count;

  // Masked-off pending bits are kept but are not eligible for selection.
  assign w_eligible = r_pending & r_mask;

  always_comb begin
    w_lowIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_eligible[i]) w_lowIdx = 3'(i);
    end
  end

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + {3'b000, r_pending[i]};
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextS       = r_s;
    w_nextValid   = r_valid;
    w_clr         = 8'h00;
    w_nextPending = 8'h00;
    if (bus.Clear) begin
      w_nextState = IDLE;
      w_nextValid = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_eligible) begin
            w_nextS     = w_lowIdx;
            w_nextValid = 1'b1;
            w_nextState = GRANT;
          end
        end
        GRANT: begin
          if (bus.Ack) begin
            w_clr       = 8'h01 << r_s;
            w_nextValid = 1'b0;
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
      // A bit re-requested on its own acknowledge edge stays pending.
      w_nextPending = (r_pending & ~w_clr) | (bus.R & r_mask);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_pending <= 8'h00;
      r_s       <= 3'd0;
      r_valid   <= 1'b0;
      r_mask    <= 8'hFF;
    end else begin
      r_state   <= w_nextState;
      r_pending <= w_nextPending;
      r_s       <= w_nextS;
      r_valid   <= w_nextValid;
      if (bus.MaskLd) r_mask <= bus.MaskIn;
    end
  end

  assign bus.S     = r_s;
  assign bus.Valid = r_valid;
  assign bus.Mask  = r_mask;
  assign bus.Count = w_count;

endmodule

// File: tb/tb_priority_encoder8to3.sv
// Scoreboarded bench for priority_encoder8to3: expected grant codes are queued
// when requests are driven and popped when the encoder raises Valid.
module tb_priority_encoder8to3;

  logic Clock;
  logic Resetn;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] expQ[$];

  priority_encoder8to3_if bus();

  priority_encoder8to3 dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic ack, input logic clr,
                               input logic maskLd, input logic [7:0] maskIn);
    bus.R      = r;
    bus.Ack    = ack;
    bus.Clear  = clr;
    bus.MaskLd = maskLd;
    bus.MaskIn = maskIn;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic waitGrant(input string tag);
    int n;
    logic [2:0] e;
    n = 0;
    while (!bus.Valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, bus.Valid}, 32'd1);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_S"}, {29'd0, bus.S}, {29'd0, e});
    end
  endtask

  // Wait for a grant, acknowledge it one cycle later, then check the retire.
  task automatic serviceGrant(input string tag, input logic [3:0] countAfter);
    waitGrant(tag);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({tag, "_ackValid"}, {31'd0, bus.Valid}, 32'd0);
    checkOutput({tag, "_ackCount"}, {28'd0, bus.Count}, {28'd0, countAfter});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Resetn = 1'b0;
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(3);
    checkOutput("rst_valid", {31'd0, bus.Valid}, 32'd0);
    checkOutput("rst_S", {29'd0, bus.S}, 32'd0);
    checkOutput("rst_mask", {24'd0, bus.Mask}, 32'hFF);
    checkOutput("rst_count", {28'd0, bus.Count}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    Resetn = 1'b1;
    tick(2);
    checkOutput("post_valid", {31'd0, bus.Valid}, 32'd0);
    checkOutput("post_count", {28'd0, bus.Count}, 32'd0);

    // Priority order: 2, 5, 7.
    applyStimulus(8'hA4, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.push_back(3'd2); expQ.push_back(3'd5); expQ.push_back(3'd7);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pri_count", {28'd0, bus.Count}, 32'd3);
    checkOutput("pri_noEarly", {31'd0, bus.Valid}, 32'd0);
    serviceGrant("pri2", 4'd2);
    serviceGrant("pri5", 4'd1);
    serviceGrant("pri7", 4'd0);

    // Masking: bit 0 masked at latch time is never latched.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hF0);
    tick();
    checkOutput("msk_mask", {24'd0, bus.Mask}, 32'hF0);
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.push_back(3'd4);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("msk_count", {28'd0, bus.Count}, 32'd1);
    serviceGrant("msk4", 4'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(2);
    checkOutput("msk_noBit0", {31'd0, bus.Valid}, 32'd0);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.push_back(3'd0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    serviceGrant("msk0", 4'd0);

    // Hold under mask changes, then re-request on the acknowledge edge.
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.push_back(3'd3);
    tick();
    waitGrant("hold3");
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b1, 8'hF7);
    tick();
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("hold_S", {29'd0, bus.S}, 32'd3);
    checkOutput("hold_valid", {31'd0, bus.Valid}, 32'd1);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    applyStimulus(8'h08, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rereq_valid", {31'd0, bus.Valid}, 32'd0);
    checkOutput("rereq_count", {28'd0, bus.Count}, 32'd1);
    tick(2);
    checkOutput("rereq_idle", {31'd0, bus.Valid}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    expQ.push_back(3'd3);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    serviceGrant("rereq3", 4'd0);

    // Clear beats Ack and R; MaskLd still applies; S holds.
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.push_back(3'd0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_pend", {28'd0, bus.Count}, 32'd4);
    waitGrant("clr0");
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b1, 8'h7F);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_valid", {31'd0, bus.Valid}, 32'd0);
    checkOutput("clr_count", {28'd0, bus.Count}, 32'd0);
    checkOutput("clr_mask", {24'd0, bus.Mask}, 32'h7F);
    checkOutput("clr_S", {29'd0, bus.S}, 32'd0);
    tick(3);
    checkOutput("clr_noGrant", {31'd0, bus.Valid}, 32'd0);

    // Ack in IDLE with a hidden pending bit; then async reset mid-grant.
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tick(2);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("idleAck_count", {28'd0, bus.Count}, 32'd1);
    checkOutput("idleAck_valid", {31'd0, bus.Valid}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    expQ.push_back(3'd2);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    waitGrant("idleAck2");
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, bus.Valid}, 32'd0);
    checkOutput("arst_count", {28'd0, bus.Count}, 32'd0);
    checkOutput("arst_S", {29'd0, bus.S}, 32'd0);
    #1;
    Resetn = 1'b1;
    tick(2);
    checkOutput("arst_after", {31'd0, bus.Valid}, 32'd0);
    checkOutput("sb_empty", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder8to3.md
# priority_encoder8to3

Registered 8-to-3 priority encoder with request latching and a valid/acknowledge handshake. It is the inverse of the 3-to-8 select decoder: eight one-hot request lines are encoded into a 3-bit select code. It sits between peripheral/interrupt request lines and the processor control unit. The control unit consumes `S` as a source/vector select and retires each request with `Ack`.

## Interface
- No parameters; widths fixed at 8 requests / 3-bit code.
- `Clock`  in  1  single system clock, rising-edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `R`  in  8  request lines; `R[i]` high during a rising edge latches request i (if unmasked).
- `MaskIn`  in  8  new mask value.
- `MaskLd`  in  1  load `MaskIn` into `Mask` on this edge.
- `Ack`  in  1  consumer retires the current grant; honoured only while `Valid`=1.
- `Clear`  in  1  synchronous flush of all pending requests and any grant.
- `S`  out  3  encoded index of granted request; registered.
- `Valid`  out  1  `S` holds a live grant; registered.
- `Mask`  out  8  current mask register; 1 = enabled.
- `Count`  out  4  population count of `Pending` (0..8), combinational from the register.

## Operation
- Internal `Pending[7:0]` register. Two-state FSM: IDLE, GRANT.
- Update order per edge: `clr` = one-hot(`S`) when state=GRANT and `Ack`=1, else 0.
- `Pending <= (Pending & ~clr) | (R & Mask)`. Uses `Mask` before any same-edge load.
- Same bit cleared and re-requested on one edge: the set wins and the bit stays pending.
- Masked-off bits already pending are retained. They are invisible to selection until unmasked.
- `Mask <= MaskIn` when `MaskLd`. It affects latching and selection from the next edge.
- IDLE:
  - If `Pending & Mask` is nonzero, load `S` with the lowest set index (bit 0 highest priority), set `Valid`=1 and go to GRANT.
  - Otherwise stay in IDLE; `S` holds its last value.
- GRANT:
  - `S` and `Valid` are held stable regardless of `R`/`Mask` changes, including masking the granted bit.
  - On `Ack`: clear the granted pending bit, `Valid`<=0, go to IDLE.
- `Ack` in IDLE is ignored, with no effect on `Pending`.
- `Clear` (highest priority after reset): `Pending`<=0, `Valid`<=0, state<=IDLE.
  - `R`, `Ack` and the FSM are ignored that edge.
  - `MaskLd` still applies.
  - `S` holds its value.
- `Count` counts all pending bits, masked or not.

## Timing
- Reset (`Resetn`=0, immediate, no clock needed):
  - `Pending`=0, state=IDLE, `S`=3'b000, `Valid`=0, `Mask`=8'hFF, `Count`=0.
- Deassertion is sampled on the next rising edge.
- Request latency: `R[i]` high at edge k gives `Pending[i]` set after k and `Count` updated after k. If that bit wins selection, `Valid`=1 with `S`=i after edge k+1.
- Ack latency: `Ack` high at edge g in GRANT drops `Valid` after g. The next grant (if any) appears after g+1.
- Maximum throughput is one grant per 2 cycles with `Ack` held high continuously.
- `R` need only be high for one edge; requests are sticky until acknowledged or cleared.
- Reset mid-GRANT discards the grant and all pending requests immediately.

## Test plan
- Reset:
  - Stimulus: hold `Resetn`=0 with `R`=8'hFF toggling the clock.
  - Response: `Valid`=0, `S`=0, `Mask`=8'hFF, `Count`=0.
  - After release, `R`=0: outputs unchanged.
- Priority:
  - Stimulus: pulse `R`=8'b1010_0100 for one edge; answer each grant with `Ack` one cycle later.
  - Response: grants `S`=2, then 5, then 7. `Count` goes 3→2→1→0. `Valid` is low between grants.
- Masking:
  - Stimulus: `Mask`=8'hF0, pulse `R`=8'h11.
  - Response: `Count`=1, grant `S`=4 only.
  - Then load `Mask`=8'hFF and pulse `R`=8'h01. Response: `S`=0, bit 0 not latched earlier.
- Hold and re-request:
  - Stimulus: in GRANT with `S`=3, change `Mask` to 8'h00 and hold `R[3]`=1 through the `Ack` edge.
  - Response: `S` stays 3 until `Ack`; `Pending[3]` remains set.
  - After restoring the mask: a new grant `S`=3.
- Clear:
  - Stimulus: pending 8'hC3 in GRANT, assert `Clear` together with `Ack` and `R`=8'h08.
  - Response: next cycle `Valid`=0, `Count`=0, no grant follows.
- Ack misuse and async reset:
  - Stimulus: `Ack` pulses in IDLE; then assert `Resetn` low mid-cycle during GRANT.
  - Response: `Ack` in IDLE has no effect. `Valid` falls without a clock edge; `Pending` is cleared.
